// File: rtl/arb_pkg.sv
// Shared definitions for the FIFO push arbiter.
//   - Default build-time widths (FIFO_DWIDTH, ARB_QWID) if not supplied.
//   - Output-register state enum (EMPTY / LOADED).
//   - NREQ derivation from the requester index width.
// Optional feature macro used by the arbiter: ARB_LOCK_EN (burst locking).
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef ARB_QWID
`define ARB_QWID 2
`endif

package arb_pkg;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } arb_state_e;

  // Number of requesters addressed by a qwid-bit index.
  function automatic int nreq_of(input int qwid);
    return 1 << qwid;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority search.
// Ports:
//   req      - per-requester valid
//   ptr      - last granted index; search starts at ptr+1
//   gnt      - one-hot grant (zero when req is zero)
//   gnt_idx  - index of the granted requester
//   gnt_vld  - a requester was found
module rr_pick
  import arb_pkg::*;
#(
  parameter  int QWID = 2,
  localparam int NREQ = nreq_of(QWID)
) (
  input  logic [NREQ-1:0] req,
  input  logic [QWID-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [QWID-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [QWID-1:0] idx;

  // QWID-bit addition wraps naturally, so k=NREQ lands back on ptr itself
  // and gives it the lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + QWID'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter feeding a single-entry output
// register that pushes into a downstream FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - per-requester valid (held until granted)
//   req_data   - per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_lock   - per-requester burst lock (used only with ARB_LOCK_EN)
//   gnt        - one-hot combinational grant (capture this cycle)
//   fifo_full  - downstream FIFO full
//   fifo_push  - push strobe to downstream FIFO
//   fifo_data  - output register data
//   gnt_id     - requester index of the word in the output register
// Macro ARB_LOCK_EN: when defined, a granted requester holding req_lock
// keeps the grant at every capture opportunity until it drops req/req_lock.
module fifo_push_arbiter
  import arb_pkg::*;
#(
  parameter  int WIDTH = `FIFO_DWIDTH,
  parameter  int QWID  = `ARB_QWID,
  localparam int NREQ  = nreq_of(QWID)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      gnt,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [WIDTH-1:0]     fifo_data,
  output logic [QWID-1:0]      gnt_id
);

  arb_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_data;
  logic [QWID-1:0]  out_id;
  logic [QWID-1:0]  ptr;
  logic             out_vld;
  logic             cap_opp;
  logic             grant;

  logic [NREQ-1:0]  pick_gnt;
  logic [QWID-1:0]  pick_idx;
  logic             pick_vld;

  logic [NREQ-1:0]  sel_gnt;
  logic [QWID-1:0]  sel_idx;
  logic             sel_vld;

  rr_pick #(.QWID(QWID)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

`ifdef ARB_LOCK_EN
  logic            lock_q;
  logic [QWID-1:0] lock_id_q;
  logic            lock_hold;

  // The lock owner wins only while it still presents both req and req_lock;
  // otherwise plain round-robin resumes from ptr (which equals the owner).
  assign lock_hold = lock_q && req[lock_id_q] && req_lock[lock_id_q];
  assign sel_gnt   = lock_hold ? (NREQ'(1) << lock_id_q) : pick_gnt;
  assign sel_idx   = lock_hold ? lock_id_q : pick_idx;
  assign sel_vld   = lock_hold | pick_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (grant) begin
      lock_q    <= req_lock[sel_idx];
      lock_id_q <= sel_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign sel_gnt     = pick_gnt;
  assign sel_idx     = pick_idx;
  assign sel_vld     = pick_vld;
`endif

  assign out_vld   = (state_q == ST_LOADED);
  // Gated by rst so a word caught in the register at reset is never pushed.
  assign fifo_push = !rst && out_vld && !fifo_full;
  assign cap_opp   = !rst && (!out_vld || fifo_push);
  assign fifo_data = out_data;
  assign gnt_id    = out_id;

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    grant   = 1'b0;
    if (cap_opp && sel_vld) begin
      grant   = 1'b1;
      gnt     = sel_gnt;
      state_d = ST_LOADED;
    end else if (fifo_push) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // ptr resets to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_id   <= '0;
      ptr      <= '1;
    end else if (grant) begin
      out_data <= req_data[sel_idx*WIDTH +: WIDTH];
      out_id   <= sel_idx;
      ptr      <= sel_idx;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_lock;
  logic [N-1:0]  gnt;
  logic          fifo_full;
  logic          fifo_push;
  logic [W-1:0]  fifo_data;
  logic [1:0]    gnt_id;

  int checks = 0;
  int errors = 0;

  fifo_push_arbiter #(.WIDTH(W), .QWID(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lock(req_lock),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_data(fifo_data), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Reference model: output register contents and last-granted index.
  logic       m_vld;
  logic [7:0] m_data;
  int         m_id, m_ptr, m_lid;
  logic       m_lock;
  logic       e_push;
  logic [3:0] e_gnt;
  int         e_g;

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [31:0] d;
    logic        f;
    logic        chk_d;
    logic [3:0]  g;
    logic        p;
    logic [7:0]  fd;
    logic [1:0]  id;
  } vec_t;
  vec_t tv[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, wait to the falling edge and compute the model's
  // expectation for this cycle.
  task automatic apply(input logic r, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] lk, input logic f);
    bit opp;
    rst = r; req = rq; req_data = d; req_lock = lk; fifo_full = f;
    @(negedge clk);
    e_push = !r && (m_vld === 1'b1) && !f;
    opp    = !r && ((m_vld !== 1'b1) || e_push);
    e_g    = -1;
    if (opp) begin
`ifdef ARB_LOCK_EN
      if (m_lock && rq[m_lid] && lk[m_lid]) e_g = m_lid;
`endif
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (e_g < 0 && rq[i]) e_g = i;
      end
    end
    e_gnt = (e_g >= 0) ? 4'(1 << e_g) : 4'd0;
  endtask

  // Commit the model for the coming edge, then move past it.
  task automatic advance();
    if (rst) begin
      m_vld = 0; m_data = 0; m_id = 0; m_ptr = N - 1; m_lock = 0; m_lid = 0;
    end else if (e_g >= 0) begin
      m_vld  = 1;
      m_data = req_data[e_g*W +: W];
      m_id   = e_g;
      m_ptr  = e_g;
      m_lock = req_lock[e_g];
      m_lid  = e_g;
    end else if (e_push) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_chk();
    chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
    chk("rnd_push", 32'(fifo_push), 32'(e_push));
    if (m_vld === 1'b1) begin
      chk("rnd_data", 32'(fifo_data), 32'(m_data));
      chk("rnd_id", 32'(gnt_id), 32'(m_id));
    end
  endtask

  initial begin
    bit         pend[N];
    logic [7:0] pdat[N];
    logic [3:0] rq, lk;
    logic [31:0] d;
    logic       r, f;

    m_vld = 1'bx; m_data = 0; m_id = 0; m_ptr = N - 1; m_lock = 0; m_lid = 0;

    // reset, fairness, backpressure, sparse wrap, mid-operation reset
    tv[0]  = '{1, 4'hF, 32'h13121110, 0, 0, 4'h0, 0, 8'h00, 2'd0};
    tv[1]  = '{1, 4'hF, 32'h13121110, 0, 1, 4'h0, 0, 8'h00, 2'd0};
    tv[2]  = '{0, 4'hF, 32'h13121110, 0, 1, 4'h1, 0, 8'h00, 2'd0};
    tv[3]  = '{0, 4'hF, 32'h13121110, 0, 1, 4'h2, 1, 8'h10, 2'd0};
    tv[4]  = '{0, 4'hF, 32'h13121110, 0, 1, 4'h4, 1, 8'h11, 2'd1};
    tv[5]  = '{0, 4'hF, 32'h13121110, 0, 1, 4'h8, 1, 8'h12, 2'd2};
    tv[6]  = '{0, 4'hF, 32'h13121110, 0, 1, 4'h1, 1, 8'h13, 2'd3};
    tv[7]  = '{0, 4'h0, 32'h13121110, 0, 1, 4'h0, 1, 8'h10, 2'd0};
    tv[8]  = '{0, 4'h1, 32'h000000A5, 0, 1, 4'h1, 0, 8'h10, 2'd0};
    tv[9]  = '{0, 4'h2, 32'h00007700, 1, 1, 4'h0, 0, 8'hA5, 2'd0};
    tv[10] = '{0, 4'h2, 32'h00007700, 1, 1, 4'h0, 0, 8'hA5, 2'd0};
    tv[11] = '{0, 4'h2, 32'h00007700, 1, 1, 4'h0, 0, 8'hA5, 2'd0};
    tv[12] = '{0, 4'h2, 32'h00007700, 0, 1, 4'h2, 1, 8'hA5, 2'd0};
    tv[13] = '{0, 4'h0, 32'h00000000, 0, 1, 4'h0, 1, 8'h77, 2'd1};
    tv[14] = '{0, 4'h8, 32'h33000000, 0, 1, 4'h8, 0, 8'h77, 2'd1};
    tv[15] = '{0, 4'h4, 32'h00220000, 0, 1, 4'h4, 1, 8'h33, 2'd3};
    tv[16] = '{0, 4'h0, 32'h00000000, 0, 1, 4'h0, 1, 8'h22, 2'd2};
    tv[17] = '{0, 4'h0, 32'h00000000, 0, 1, 4'h0, 0, 8'h22, 2'd2};
    tv[18] = '{0, 4'h1, 32'h0000005A, 0, 1, 4'h1, 0, 8'h22, 2'd2};
    tv[19] = '{0, 4'h0, 32'h00000000, 1, 1, 4'h0, 0, 8'h5A, 2'd0};
    tv[20] = '{1, 4'h0, 32'h00000000, 1, 1, 4'h0, 0, 8'h5A, 2'd0};
    tv[21] = '{0, 4'h0, 32'h00000000, 0, 1, 4'h0, 0, 8'h00, 2'd0};
    tv[22] = '{0, 4'h0, 32'h00000000, 0, 1, 4'h0, 0, 8'h00, 2'd0};

    for (int v = 0; v < 23; v++) begin
      apply(tv[v].r, tv[v].rq, tv[v].d, 4'h0, tv[v].f);
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(tv[v].g));
      chk($sformatf("vec%0d_push", v), 32'(fifo_push), 32'(tv[v].p));
      if (tv[v].chk_d) begin
        chk($sformatf("vec%0d_data", v), 32'(fifo_data), 32'(tv[v].fd));
        chk($sformatf("vec%0d_id", v), 32'(gnt_id), 32'(tv[v].id));
      end
      advance();
    end

`ifdef ARB_LOCK_EN
    // burst lock: requester 0 keeps the grant while it holds req_lock
    apply(1, 4'h0, 32'h0, 4'h0, 0); advance();
    for (int c = 0; c < 3; c++) begin
      apply(0, 4'h3, 32'h0000BBAA, 4'h1, 0);
      chk($sformatf("lock%0d_gnt", c), 32'(gnt), 32'h1);
      advance();
    end
    apply(0, 4'h3, 32'h0000BBAA, 4'h0, 0);
    chk("lock_release_gnt", 32'(gnt), 32'h2);
    advance();
`endif

    // randomized traffic against the model; requesters hold until granted
    apply(1, 4'h0, 32'h0, 4'h0, 0); advance();
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdat[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      rq = 0; d = 0; lk = 0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pdat[i] = 8'($urandom);
        end
        rq[i] = pend[i];
        d[i*W +: W] = pdat[i];
        lk[i] = ($urandom_range(0, 2) != 0);
      end
      r = ($urandom_range(0, 59) == 0);
      f = ($urandom_range(0, 9) < 3);
      apply(r, rq, d, lk, f);
      model_chk();
      if (e_g >= 0) begin
        // a locking requester often comes straight back with new data
        pend[e_g] = lk[e_g] && ($urandom_range(0, 3) != 0);
        pdat[e_g] = 8'($urandom);
      end
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
